instr_encoder: RTL and testbench

Streaming RV32I instruction encoder for the subset the core's `control` decoder recognises: ADDI, XORI, ORI, ANDI, ADD, XOR, OR, AND, SW, BEQ, BNE, JAL, JALR. It accepts field-level instruction descriptors over a valid/ready handshake and range-checks immediates. It emits 32-bit machine words with sequential word addresses, to be written into instruction memory by the program loader / test harness. It is the producer side of the encoding the decoder consumes.

---
 rtl/instr_encoder.sv | 210 +++++++++++++++++++++
 tb/tb_instr_encoder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder
//   Streaming RV32I encoder for the subset understood by the core's control
//   decoder. Field-level descriptors come in over valid/ready; 32-bit machine
//   words leave through a single output register together with a sequential
//   word address, ready for the program loader to write into instruction
//   memory. Out-of-range immediates, misaligned branch/jump offsets and
//   illegal ops are replaced by a NOP (addi x0,x0,0) and flagged.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   start, base_addr      begin a load at base_addr (honoured in IDLE only)
//   in_valid/in_ready     descriptor handshake
//   in_op, in_rd, in_rs1, in_rs2, in_imm, in_last   descriptor fields
//   out_valid/out_ready   encoded word handshake
//   out_instr, out_addr, out_err                     encoded word, address, NOP flag
//   busy, done, err_cnt   status: not idle, end-of-load pulse, saturating errors

module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              busy,
  output logic              done,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_ADDI = 4'd0,  OP_XORI = 4'd1, OP_ORI = 4'd2, OP_ANDI = 4'd3,
    OP_ADD  = 4'd4,  OP_XOR  = 4'd5, OP_OR  = 4'd6, OP_AND  = 4'd7,
    OP_SW   = 4'd8,  OP_BEQ  = 4'd9, OP_BNE = 4'd10, OP_JAL = 4'd11,
    OP_JALR = 4'd12
  } op_e;

  // Descriptor as seen by the encoder
  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } desc_t;

  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              accept;
  desc_t             desc;
  logic [31:0]       enc_word;
  logic              enc_bad;

  assign desc   = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Encoder (combinational, on the live descriptor)
  // ---------------------------------------------------------------------------
  logic signed [31:0] imm_s;
  logic               i_ok, b_ok, j_ok;
  logic [2:0]         f3;
  logic [31:0]        raw;

  assign imm_s = signed'(desc.imm);
  // Branch and JAL offsets are in bytes but encoded in halfwords, so bit 0
  // must be clear; the top of each range is therefore even.
  assign i_ok  = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
  assign b_ok  = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4094)    && !desc.imm[0];
  assign j_ok  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !desc.imm[0];

  always_comb begin
    f3      = 3'b000;
    raw     = NOP;
    enc_bad = 1'b0;
    case (op_e'(desc.op))
      OP_ADDI, OP_ADD: f3 = 3'b000;
      OP_XORI, OP_XOR: f3 = 3'b100;
      OP_ORI,  OP_OR:  f3 = 3'b110;
      OP_ANDI, OP_AND: f3 = 3'b111;
      OP_SW:           f3 = 3'b010;
      OP_BNE:          f3 = 3'b001;
      default:         f3 = 3'b000;
    endcase
    case (op_e'(desc.op))
      OP_ADDI, OP_XORI, OP_ORI, OP_ANDI: begin
        raw     = {desc.imm[11:0], desc.rs1, f3, desc.rd, OPC_OPIMM};
        enc_bad = !i_ok;
      end
      OP_JALR: begin
        raw     = {desc.imm[11:0], desc.rs1, 3'b000, desc.rd, OPC_JALR};
        enc_bad = !i_ok;
      end
      OP_ADD, OP_XOR, OP_OR, OP_AND: begin
        raw     = {7'b0, desc.rs2, desc.rs1, f3, desc.rd, OPC_OP};
      end
      OP_SW: begin
        raw     = {desc.imm[11:5], desc.rs2, desc.rs1, f3, desc.imm[4:0], OPC_STORE};
        enc_bad = !i_ok;
      end
      OP_BEQ, OP_BNE: begin
        raw     = {desc.imm[12], desc.imm[10:5], desc.rs2, desc.rs1, f3,
                   desc.imm[4:1], desc.imm[11], OPC_BRANCH};
        enc_bad = !b_ok;
      end
      OP_JAL: begin
        raw     = {desc.imm[20], desc.imm[10:1], desc.imm[11], desc.imm[19:12],
                   desc.rd, OPC_JAL};
        enc_bad = !j_ok;
      end
      default: enc_bad = 1'b1;  // ops 13-15
    endcase
  end

  assign enc_word = enc_bad ? NOP : raw;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        // Accept whenever the output register is free or draining this cycle,
        // which gives full throughput with no bubble on reload.
        in_ready = !out_valid || out_ready;
        if (in_valid && in_ready && in_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!out_valid || out_ready) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address counter and error counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      err_cnt <= '0;
    end else if (state_q == S_IDLE && start) begin
      addr_q  <= base_addr;
      err_cnt <= '0;
    end else if (accept) begin
      addr_q <= addr_q + 1'b1;  // wraps silently
      if (enc_bad && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register: payload only changes on an accept, so it stays stable
  // across a stall; valid drops once the word is taken with nothing behind it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= enc_word;
      out_addr  <= addr_q;
      out_err   <= enc_bad;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic        out_err;
  logic        busy;
  logic        done;
  logic [7:0]  err_cnt;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_err(out_err), .busy(busy), .done(done),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Output monitor: samples 1 time unit after the falling edge
  logic [31:0] q_instr[$];
  logic [7:0]  q_addr[$];
  logic        q_err[$];
  int          hs_cyc[$];
  int          cyc = 0, done_cnt = 0, done_cyc = -1;
  int          stab_bad = 0, stall_cyc = 0, rdy_drop = 0;
  logic        stall_p = 1'b0, p_err;
  logic [31:0] p_instr;
  logic [7:0]  p_addr;

  always @(negedge clk) begin
    #1;
    cyc++;
    if (out_valid && out_ready) begin
      q_instr.push_back(out_instr);
      q_addr.push_back(out_addr);
      q_err.push_back(out_err);
      hs_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (stall_p && (!out_valid || out_instr != p_instr || out_addr != p_addr || out_err != p_err))
      stab_bad++;
    stall_p = out_valid && !out_ready;
    if (stall_p) stall_cyc++;
    p_instr = out_instr;
    p_addr  = out_addr;
    p_err   = out_err;
    if (busy && in_valid && !in_ready && out_ready) rdy_drop++;
  end

  task automatic clear_q();
    q_instr.delete(); q_addr.delete(); q_err.delete(); hs_cyc.delete();
    stab_bad = 0; stall_cyc = 0; rdy_drop = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after the accept
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_last = last;
    for (int t = 0; t < 50 && !acc; t++) begin
      #1;
      acc = in_ready;
      @(negedge clk);
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic load_start(input logic [7:0] b);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100 && busy; t++) @(negedge clk);
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_word(input int i, input logic [31:0] ei, input logic [7:0] ea, input logic ee);
    if (q_instr.size() <= i) begin
      chk($sformatf("missing_word%0d", i), q_instr.size(), i + 1);
    end else begin
      chk($sformatf("instr%0d", i), q_instr[i], ei);
      chk($sformatf("addr%0d", i), {24'd0, q_addr[i]}, {24'd0, ea});
      chk($sformatf("err%0d", i), {31'd0, q_err[i]}, {31'd0, ee});
    end
  endtask

  logic [31:0] exp_b2b [8] = '{32'h0FF2C213, 32'h8003E313, 32'h7FF4F413, 32'h00C5C533,
                               32'h00F766B3, 32'h0128F833, 32'h004280E7, 32'h00208463};

  int d0;

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_op = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready",  {31'd0, in_ready}, 0);
    chk("rst_busy",      {31'd0, busy}, 0);
    chk("rst_done",      {31'd0, done}, 0);
    chk("rst_out_err",   {31'd0, out_err}, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_addr",  {24'd0, out_addr}, 0);
    chk("rst_err_cnt",   {24'd0, err_cnt}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- Encodings and error handling ----
    clear_q();
    d0 = done_cnt;
    load_start(8'h10);
    chk("t1_busy", {31'd0, busy}, 1);
    send(4'd0,  5'd1, 5'd2, 5'd0, -32'sd1,  1'b0);   // ADDI
    send(4'd4,  5'd3, 5'd1, 5'd2, 32'd0,    1'b0);   // ADD
    send(4'd8,  5'd0, 5'd2, 5'd5, 32'd8,    1'b0);   // SW
    send(4'd10, 5'd0, 5'd1, 5'd0, -32'sd4,  1'b0);   // BNE
    send(4'd11, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);   // JAL
    send(4'd0,  5'd1, 5'd2, 5'd0, 32'd2048, 1'b0);   // ADDI out of range
    send(4'd9,  5'd0, 5'd1, 5'd2, 32'd3,    1'b0);   // BEQ odd offset
    send(4'd14, 5'd1, 5'd1, 5'd1, 32'd0,    1'b1);   // illegal op
    in_valid = 1'b0; in_last = 1'b0;
    wait_idle();
    chk("t1_count", q_instr.size(), 8);
    chk_word(0, 32'hFFF10093, 8'h10, 1'b0);
    chk_word(1, 32'h002081B3, 8'h11, 1'b0);
    chk_word(2, 32'h00512423, 8'h12, 1'b0);
    chk_word(3, 32'hFE009EE3, 8'h13, 1'b0);
    chk_word(4, 32'h001000EF, 8'h14, 1'b0);
    chk_word(5, 32'h00000013, 8'h15, 1'b1);
    chk_word(6, 32'h00000013, 8'h16, 1'b1);
    chk_word(7, 32'h00000013, 8'h17, 1'b1);
    chk("t1_done_pulses", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    chk("t1_err_cnt_held", {24'd0, err_cnt}, 3);

    // ---- Address wrap with output stall ----
    clear_q();
    d0 = done_cnt;
    load_start(8'hFE);
    fork
      begin
        send(4'd0, 5'd1, 5'd2, 5'd0, -32'sd1, 1'b0);
        send(4'd4, 5'd3, 5'd1, 5'd2, 32'd0,   1'b0);
        send(4'd8, 5'd0, 5'd2, 5'd5, 32'd8,   1'b1);
        in_valid = 1'b0; in_last = 1'b0;
      end
      begin
        for (int t = 0; t < 50 && q_instr.size() < 1; t++) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    wait_idle();
    chk("t2_count", q_instr.size(), 3);
    chk_word(0, 32'hFFF10093, 8'hFE, 1'b0);
    chk_word(1, 32'h002081B3, 8'hFF, 1'b0);
    chk_word(2, 32'h00512423, 8'h00, 1'b0);
    chk("t2_stall_seen", stall_cyc, 2);
    chk("t2_stable", stab_bad, 0);
    chk("t2_done_pulses", done_cnt - d0, 1);
    if (hs_cyc.size() == 3) chk("t2_done_timing", done_cyc, hs_cyc[2] + 1);
    else                    chk("t2_hs_count", hs_cyc.size(), 3);
    chk("t2_err_cnt", {24'd0, err_cnt}, 0);

    // ---- Back-to-back, start ignored mid-load ----
    clear_q();
    d0 = done_cnt;
    load_start(8'h20);
    fork
      begin
        send(4'd1,  5'd4,  5'd5,  5'd0,  32'h0FF,   1'b0);  // XORI
        send(4'd2,  5'd6,  5'd7,  5'd0,  -32'sd2048, 1'b0); // ORI
        send(4'd3,  5'd8,  5'd9,  5'd0,  32'd2047,  1'b0);  // ANDI
        send(4'd5,  5'd10, 5'd11, 5'd12, 32'd0,     1'b0);  // XOR
        send(4'd6,  5'd13, 5'd14, 5'd15, 32'd0,     1'b0);  // OR
        send(4'd7,  5'd16, 5'd17, 5'd18, 32'd0,     1'b0);  // AND
        send(4'd12, 5'd1,  5'd5,  5'd0,  32'd4,     1'b0);  // JALR
        send(4'd9,  5'd0,  5'd1,  5'd2,  32'd8,     1'b1);  // BEQ
        in_valid = 1'b0; in_last = 1'b0;
      end
      begin
        for (int t = 0; t < 50 && q_instr.size() < 3; t++) @(negedge clk);
        start = 1'b1; base_addr = 8'h40;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_idle();
    chk("t3_count", q_instr.size(), 8);
    for (int i = 0; i < 8; i++) chk_word(i, exp_b2b[i], 8'h20 + 8'(i), 1'b0);
    if (hs_cyc.size() == 8) chk("t3_consecutive", hs_cyc[7] - hs_cyc[0], 7);
    chk("t3_in_ready_drop", rdy_drop, 0);
    chk("t3_done_pulses", done_cnt - d0, 1);
    repeat (3) @(negedge clk);
    chk("t3_idle_after", {31'd0, busy}, 0);

    // ---- Reset mid-load ----
    clear_q();
    load_start(8'h80);
    send(4'd0, 5'd1, 5'd0, 5'd0, 32'd1,    1'b0);
    send(4'd0, 5'd1, 5'd0, 5'd0, 32'd5000, 1'b0);
    in_valid = 1'b0;
    chk("t4_pre_valid", {31'd0, out_valid}, 1);
    chk("t4_pre_err", {31'd0, out_err}, 1);
    chk("t4_pre_addr", {24'd0, out_addr}, 32'h81);
    chk("t4_pre_err_cnt", {24'd0, err_cnt}, 1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", {31'd0, out_valid}, 0);
    chk("t4_rst_instr", out_instr, 0);
    chk("t4_rst_addr", {24'd0, out_addr}, 0);
    chk("t4_rst_err", {31'd0, out_err}, 0);
    chk("t4_rst_busy", {31'd0, busy}, 0);
    chk("t4_rst_err_cnt", {24'd0, err_cnt}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_no_done", done_cnt - d0, 0);
    clear_q();
    d0 = done_cnt;
    load_start(8'h30);
    chk("t4_restart_err_cnt", {24'd0, err_cnt}, 0);
    send(4'd4, 5'd3, 5'd1, 5'd2, 32'd0,    1'b0);
    send(4'd0, 5'd1, 5'd2, 5'd0, -32'sd1,  1'b1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_idle();
    chk("t4_count", q_instr.size(), 2);
    chk_word(0, 32'h002081B3, 8'h30, 1'b0);
    chk_word(1, 32'hFFF10093, 8'h31, 1'b0);
    chk("t4_done_pulses", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
